// File: rtl/xbar_ctrl_rr_pkg.sv
// Shared switch definitions: mesh port indices, default port count and
// the helpers used to size and walk port indices.
package xbar_ctrl_rr_pkg;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  localparam int PORT_N_DEF = 5;

  // Width of one port index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // (a + b) mod n for a, b < n, without a divider or a power-of-2 assumption.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/xbar_ctrl_rr_if.sv
// Handshake bundle between the switch controller, the input/output FIFOs
// and the routing-computation logic.
interface xbar_ctrl_rr_if
  import xbar_ctrl_rr_pkg::*;
#(
  parameter int PORT_N = PORT_N_DEF
);
  localparam int SEL_W = sel_width(PORT_N);

  logic [PORT_N-1:0]       empty_i;
  logic [PORT_N-1:0]       rd_en_o;
  logic [PORT_N-1:0]       vld_input_o;
  logic [PORT_N*SEL_W-1:0] dest_i;
  logic [PORT_N-1:0]       full_i;
  logic [PORT_N-1:0]       wr_en_o;
  logic [PORT_N*SEL_W-1:0] xbar_sel_o;
  logic                    err_o;

  // Environment side: FIFOs and routing logic.
  modport master (
    output empty_i, dest_i, full_i,
    input  rd_en_o, vld_input_o, wr_en_o, xbar_sel_o, err_o
  );

  // Controller side.
  modport slave (
    input  empty_i, dest_i, full_i,
    output rd_en_o, vld_input_o, wr_en_o, xbar_sel_o, err_o
  );

endinterface

// File: rtl/xbar_ctrl_rr_rr_arbiter.sv
// Round-robin arbiter for one output port: grants the first requester at or
// after the pointer, then moves the pointer just past the winner.
module rr_arbiter
  import xbar_ctrl_rr_pkg::*;
#(
  parameter int N = PORT_N_DEF,
  parameter int W = sel_width(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic         gnt_vld,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] ptr_q;

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Walk farthest-first so the candidate closest to the pointer wins last.
    for (int k = N - 1; k >= 0; k--) begin
      if (en && req[wrap_add(int'(ptr_q), k, N)]) begin
        gnt_vld = 1'b1;
        gnt_idx = W'(wrap_add(int'(ptr_q), k, N));
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + W'(1);
    end
  end

endmodule

// File: rtl/xbar_ctrl_rr.sv
// Crossbar scheduler for the mesh XY switch: one head-flit staging slot per
// input, one round-robin arbiter per output, refill in the cycle of a grant.
module xbar_ctrl_rr
  import xbar_ctrl_rr_pkg::*;
#(
  parameter int PORT_N = PORT_N_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  xbar_ctrl_rr_if.slave bus
);

  localparam int SEL_W = sel_width(PORT_N);

  logic [PORT_N-1:0]       vld_q;
  logic                    err_q;
  logic [PORT_N-1:0]       req [PORT_N];
  logic [PORT_N-1:0]       ill;
  logic [PORT_N-1:0]       granted;
  logic [PORT_N-1:0]       served;
  logic [PORT_N-1:0]       rd_en;
  logic [PORT_N-1:0]       wr_en;
  logic [PORT_N-1:0]       gnt_vld;
  logic [SEL_W-1:0]        gnt_idx [PORT_N];
  logic [PORT_N*SEL_W-1:0] sel_flat;
  logic                    sel_clash;

  // Request matrix: an input asks only for the output its staged flit names.
  always_comb begin
    ill = '0;
    for (int o = 0; o < PORT_N; o++) req[o] = '0;
    for (int i = 0; i < PORT_N; i++) begin
      ill[i] = vld_q[i] && (int'(bus.dest_i[i*SEL_W +: SEL_W]) >= PORT_N);
      for (int o = 0; o < PORT_N; o++) begin
        req[o][i] = vld_q[i] && (bus.dest_i[i*SEL_W +: SEL_W] == SEL_W'(o));
      end
    end
  end

  for (genvar o = 0; o < PORT_N; o++) begin : g_arb
    rr_arbiter #(
      .N (PORT_N),
      .W (SEL_W)
    ) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req     (req[o]),
      .en      (~bus.full_i[o]),
      .gnt_vld (gnt_vld[o]),
      .gnt_idx (gnt_idx[o])
    );
  end

  always_comb begin
    granted = '0;
    for (int o = 0; o < PORT_N; o++) begin
      for (int i = 0; i < PORT_N; i++) begin
        if (gnt_vld[o] && (int'(gnt_idx[o]) == i)) granted[i] = 1'b1;
      end
    end
  end

  // A dropped illegal flit counts as served so its slot can refill.
  assign served = granted | ill;
  assign rd_en  = rst_i ? '0 : (~bus.empty_i & (~vld_q | served));
  assign wr_en  = rst_i ? '0 : gnt_vld;

  always_comb begin
    sel_flat = '0;
    for (int o = 0; o < PORT_N; o++) begin
      if (wr_en[o]) sel_flat[o*SEL_W +: SEL_W] = gnt_idx[o];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= rd_en | (vld_q & ~served);
      err_q <= err_q | (|ill);
    end
  end

  assign bus.rd_en_o     = rd_en;
  assign bus.wr_en_o     = wr_en;
  assign bus.xbar_sel_o  = sel_flat;
  assign bus.vld_input_o = vld_q;
  assign bus.err_o       = err_q;

  always_comb begin
    sel_clash = 1'b0;
    for (int a = 0; a < PORT_N; a++) begin
      for (int b = a + 1; b < PORT_N; b++) begin
        if (wr_en[a] && wr_en[b] && (gnt_idx[a] == gnt_idx[b])) sel_clash = 1'b1;
      end
    end
  end

  a_no_overwrite: assert property (@(posedge clk_i) disable iff (rst_i)
    (rd_en & vld_q & ~served) == '0);
  a_no_write_full: assert property (@(posedge clk_i) disable iff (rst_i)
    (wr_en & bus.full_i) == '0);
  a_no_read_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    (rd_en & bus.empty_i) == '0);
  a_sel_distinct: assert property (@(posedge clk_i) disable iff (rst_i)
    !sel_clash);

endmodule

// File: tb/tb_xbar_ctrl_rr.sv
// Directed bench for xbar_ctrl_rr: reset, single flit, round-robin contention,
// backpressure, parallel transfers, illegal destination and mid-run reset.
module tb_xbar_ctrl_rr;
  import xbar_ctrl_rr_pkg::*;

  localparam int N = 5;
  localparam int W = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  xbar_ctrl_rr_if #(.PORT_N(N)) bus ();

  xbar_ctrl_rr #(.PORT_N(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_dest(input int i, input int d);
    bus.dest_i[i*W +: W] = W'(d);
  endtask

  function automatic logic [W-1:0] sel_of(input int o);
    return bus.xbar_sel_o[o*W +: W];
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    bus.empty_i = '1;
    bus.full_i  = '0;
    bus.dest_i  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.empty_i = '0;
    bus.full_i  = '0;
    bus.dest_i  = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      checks++;
      if (bus.rd_en_o !== 5'b00000) begin
        errors++;
        $display("FAIL reset_rd_en c%0d: got %b expected 00000", c, bus.rd_en_o);
      end
      checks++;
      if (bus.wr_en_o !== 5'b00000) begin
        errors++;
        $display("FAIL reset_wr_en c%0d: got %b expected 00000", c, bus.wr_en_o);
      end
      checks++;
      if (bus.vld_input_o !== 5'b00000) begin
        errors++;
        $display("FAIL reset_vld c%0d: got %b expected 00000", c, bus.vld_input_o);
      end
    end
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (bus.rd_en_o !== 5'b11111) begin
      errors++;
      $display("FAIL reset_release_rd_en: got %b expected 11111", bus.rd_en_o);
    end
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", bus.err_o);
    end
  endtask

  task automatic test_single_flit();
    do_reset();
    set_dest(1, SOUTH);
    bus.empty_i = 5'b11101;
    settle();
    checks++;
    if (bus.rd_en_o !== 5'b00010) begin
      errors++;
      $display("FAIL single_c0_rd_en: got %b expected 00010", bus.rd_en_o);
    end
    tick();
    bus.empty_i = 5'b11111;
    settle();
    checks++;
    if (bus.vld_input_o !== 5'b00010) begin
      errors++;
      $display("FAIL single_c1_vld: got %b expected 00010", bus.vld_input_o);
    end
    checks++;
    if (bus.wr_en_o !== 5'b01000) begin
      errors++;
      $display("FAIL single_c1_wr_en: got %b expected 01000", bus.wr_en_o);
    end
    checks++;
    if (sel_of(3) !== 3'd1) begin
      errors++;
      $display("FAIL single_c1_sel3: got %0d expected 1", sel_of(3));
    end
    checks++;
    if (bus.rd_en_o !== 5'b00000) begin
      errors++;
      $display("FAIL single_c1_rd_en: got %b expected 00000", bus.rd_en_o);
    end
    tick();
    settle();
    checks++;
    if (bus.vld_input_o !== 5'b00000) begin
      errors++;
      $display("FAIL single_c2_vld: got %b expected 00000", bus.vld_input_o);
    end
    checks++;
    if (bus.wr_en_o !== 5'b00000) begin
      errors++;
      $display("FAIL single_c2_wr_en: got %b expected 00000", bus.wr_en_o);
    end
  endtask

  task automatic test_contention();
    int exp_win [6];
    logic [N-1:0] exp_rd;
    exp_win = '{0, 2, 4, 0, 2, 4};
    do_reset();
    set_dest(0, SOUTH);
    set_dest(2, SOUTH);
    set_dest(4, SOUTH);
    bus.empty_i = 5'b01010;
    settle();
    checks++;
    if (bus.rd_en_o !== 5'b10101) begin
      errors++;
      $display("FAIL cont_fill_rd_en: got %b expected 10101", bus.rd_en_o);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      settle();
      exp_rd = '0;
      exp_rd[exp_win[c]] = 1'b1;
      checks++;
      if (bus.wr_en_o !== 5'b01000) begin
        errors++;
        $display("FAIL cont_wr_en c%0d: got %b expected 01000", c, bus.wr_en_o);
      end
      checks++;
      if (int'(sel_of(3)) != exp_win[c]) begin
        errors++;
        $display("FAIL cont_sel3 c%0d: got %0d expected %0d", c, sel_of(3), exp_win[c]);
      end
      checks++;
      if (bus.rd_en_o !== exp_rd) begin
        errors++;
        $display("FAIL cont_rd_en c%0d: got %b expected %b", c, bus.rd_en_o, exp_rd);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_dest(1, SOUTH);
    bus.empty_i = 5'b11101;
    bus.full_i  = 5'b01000;
    settle();
    checks++;
    if (bus.rd_en_o !== 5'b00010) begin
      errors++;
      $display("FAIL bp_fill_rd_en: got %b expected 00010", bus.rd_en_o);
    end
    tick();
    bus.empty_i = 5'b11101;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (bus.wr_en_o !== 5'b00000) begin
        errors++;
        $display("FAIL bp_hold_wr_en c%0d: got %b expected 00000", c, bus.wr_en_o);
      end
      checks++;
      if (bus.vld_input_o !== 5'b00010) begin
        errors++;
        $display("FAIL bp_hold_vld c%0d: got %b expected 00010", c, bus.vld_input_o);
      end
      checks++;
      if (bus.rd_en_o !== 5'b00000) begin
        errors++;
        $display("FAIL bp_hold_rd_en c%0d: got %b expected 00000", c, bus.rd_en_o);
      end
      tick();
    end
    bus.full_i = 5'b00000;
    settle();
    checks++;
    if (bus.wr_en_o !== 5'b01000) begin
      errors++;
      $display("FAIL bp_release_wr_en: got %b expected 01000", bus.wr_en_o);
    end
    checks++;
    if (sel_of(3) !== 3'd1) begin
      errors++;
      $display("FAIL bp_release_sel3: got %0d expected 1", sel_of(3));
    end
    checks++;
    if (bus.rd_en_o !== 5'b00010) begin
      errors++;
      $display("FAIL bp_release_refill: got %b expected 00010", bus.rd_en_o);
    end
    tick();
    bus.empty_i = 5'b11111;
    tick();
  endtask

  task automatic test_parallel();
    logic [N*W-1:0] exp_sel;
    exp_sel = '0;
    exp_sel[2*W +: W] = 3'd0;
    exp_sel[3*W +: W] = 3'd1;
    exp_sel[4*W +: W] = 3'd2;
    do_reset();
    set_dest(0, EAST);
    set_dest(1, SOUTH);
    set_dest(2, WEST);
    bus.empty_i = 5'b11000;
    settle();
    checks++;
    if (bus.rd_en_o !== 5'b00111) begin
      errors++;
      $display("FAIL par_fill_rd_en: got %b expected 00111", bus.rd_en_o);
    end
    tick();
    bus.empty_i = 5'b11111;
    settle();
    checks++;
    if (bus.wr_en_o !== 5'b11100) begin
      errors++;
      $display("FAIL par_wr_en: got %b expected 11100", bus.wr_en_o);
    end
    checks++;
    if (bus.xbar_sel_o !== exp_sel) begin
      errors++;
      $display("FAIL par_xbar_sel: got %h expected %h", bus.xbar_sel_o, exp_sel);
    end
  endtask

  task automatic test_illegal_and_reset();
    do_reset();
    set_dest(4, 7);
    set_dest(0, NORTH);
    bus.empty_i = 5'b01110;
    settle();
    checks++;
    if (bus.rd_en_o !== 5'b10001) begin
      errors++;
      $display("FAIL ill_fill_rd_en: got %b expected 10001", bus.rd_en_o);
    end
    tick();
    bus.empty_i = 5'b11111;
    settle();
    checks++;
    if (bus.wr_en_o !== 5'b00010 || sel_of(1) !== 3'd0) begin
      errors++;
      $display("FAIL ill_side_traffic: got wr_en %b sel1 %0d expected 00010 sel1 0",
               bus.wr_en_o, sel_of(1));
    end
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL ill_err_early: got %b expected 0", bus.err_o);
    end
    tick();
    settle();
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL ill_err_set: got %b expected 1", bus.err_o);
    end
    checks++;
    if (bus.vld_input_o !== 5'b00000) begin
      errors++;
      $display("FAIL ill_dropped_vld: got %b expected 00000", bus.vld_input_o);
    end
    tick();
    bus.empty_i = 5'b11110;
    bus.full_i  = 5'b00010;
    settle();
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL ill_err_sticky: got %b expected 1", bus.err_o);
    end
    tick();
    settle();
    checks++;
    if (bus.vld_input_o !== 5'b00001) begin
      errors++;
      $display("FAIL mid_staged_vld: got %b expected 00001", bus.vld_input_o);
    end
    tick();
    rst         = 1'b1;
    bus.full_i  = 5'b00000;
    settle();
    checks++;
    if (bus.rd_en_o !== 5'b00000 || bus.wr_en_o !== 5'b00000 || bus.xbar_sel_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_forced: got rd %b wr %b sel %h expected all zero",
               bus.rd_en_o, bus.wr_en_o, bus.xbar_sel_o);
    end
    tick();
    rst         = 1'b0;
    bus.empty_i = 5'b11111;
    settle();
    checks++;
    if (bus.vld_input_o !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset_vld: got %b expected 00000", bus.vld_input_o);
    end
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_err: got %b expected 0", bus.err_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_flit();
    test_contention();
    test_backpressure();
    test_parallel();
    test_illegal_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
